rgmii_rx_framer: RTL and testbench

Parametrised receive framer behind the RGMII receiver, in the `clk_125` domain. It takes the decoded byte stream (`rx_data`/`rx_dv`/`rx_er`) and strips preamble and SFD. It assembles bytes into `OUT_BYTES`-wide stream beats with keep/last/error sideband and reports per-frame length and status. It also supports 10/100 nibble mode, which the plain receiver path does not.

---
 rtl/rgmii_pkg.sv | 23 ++
 rtl/crc32_d8.sv | 20 ++
 rtl/rgmii_rx_framer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_rgmii_rx_framer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII receive framer.
package rgmii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  // Good-frame residue, in non-reflected bit order.
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide combinational CRC-32 step, reflected (LSB-first) form.
module crc32_d8
  import rgmii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] POLY_R = bitrev32(CRC_POLY);

  // Eight serial shift/xor steps folded into one cycle.
  always_comb begin
    logic [31:0] c;
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
    crc_o = c;
  end

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD, packs bytes into OUT_BYTES-wide
// beats with keep/last/user, reports per-frame length and status.
// Optional FCS check: define RGMII_RX_FCS_CHECK_EN.
module rgmii_rx_framer
  import rgmii_pkg::*;
#(
  parameter int OUT_BYTES = 1,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518
) (
  input  logic                   clk_125,
  input  logic                   rst,
  input  logic                   mii_mode,
  input  logic [7:0]             rx_data,
  input  logic                   rx_dv,
  input  logic                   rx_er,
  output logic [8*OUT_BYTES-1:0] m_data,
  output logic [OUT_BYTES-1:0]   m_keep,
  output logic                   m_valid,
  output logic                   m_last,
  output logic                   m_user,
  output logic                   frame_done,
  output logic [15:0]            frame_len,
  output logic                   frame_err
);

  localparam int LW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  rx_state_e                   state_q, state_d;
  logic                        mode_q, mode_d;
  logic                        dv_q;
  logic                        nib_q, nib_d;
  logic [3:0]                  lo_q, lo_d;
  logic [2:0]                  pre_cnt_q, pre_cnt_d;
  logic [LW-1:0]               lane_q, lane_d;
  logic [OUT_BYTES-1:0][7:0]   acc_q, acc_d, acc_ins;
  logic [OUT_BYTES-1:0][7:0]   hold_q, hold_d;
  logic                        hold_v_q, hold_v_d;
  logic [15:0]                 len_q, len_d;
  logic                        err_q, err_d;

  logic [8*OUT_BYTES-1:0]      m_data_q, m_data_d;
  logic [OUT_BYTES-1:0]        m_keep_q, m_keep_d, part_keep;
  logic                        m_valid_q, m_valid_d;
  logic                        m_last_q, m_last_d;
  logic                        m_user_q, m_user_d;
  logic                        done_q, done_d;
  logic [15:0]                 flen_q, flen_d;
  logic                        ferr_q, ferr_d;

  logic                        mode_eff, byte_v, rise, enter_pl, bad, fcs_bad;
  logic [7:0]                  byte_w;

`ifdef RGMII_RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_nxt;
  crc32_d8 u_crc (.crc_i(crc_q), .data_i(byte_w), .crc_o(crc_nxt));
  assign fcs_bad = (bitrev32(crc_q) != CRC_RESIDUE);
`else
  assign fcs_bad = 1'b0;
`endif

  // Mode is live while idle, frozen for the rest of the frame.
  assign mode_eff = (state_q == ST_IDLE) ? mii_mode : mode_q;
  assign byte_v   = rx_dv && (!mode_eff || nib_q);
  assign byte_w   = mode_eff ? {rx_data[3:0], lo_q} : rx_data;
  // dv_q resets high so a frame already in flight at reset release is dropped.
  assign rise     = rx_dv && !dv_q;
  assign bad      = err_q | nib_q | fcs_bad |
                    ({16'd0, len_q} < 32'(MIN_LEN)) | ({16'd0, len_q} > 32'(MAX_LEN));

  // Current accumulator with the incoming byte dropped into its lane, and
  // the keep mask for a partially filled word.
  always_comb begin
    acc_ins   = acc_q;
    part_keep = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (lane_q == LW'(i)) acc_ins[i] = byte_w;
      part_keep[i] = (LW'(i) < lane_q);
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    nib_d     = rx_dv && mode_eff && !nib_q;
    lo_d      = (rx_dv && mode_eff && !nib_q) ? rx_data[3:0] : lo_q;
    pre_cnt_d = pre_cnt_q;
    lane_d    = lane_q;
    acc_d     = acc_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    len_d     = len_q;
    err_d     = err_q;
    enter_pl  = 1'b0;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_valid_d = 1'b0;
    m_last_d  = 1'b0;
    m_user_d  = 1'b0;
    done_d    = 1'b0;
    flen_d    = flen_q;
    ferr_d    = ferr_q;
`ifdef RGMII_RX_FCS_CHECK_EN
    crc_d     = crc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rx_dv) begin
          mode_d = mii_mode;
          if (!rise) begin
            state_d = ST_DROP;
          end else if (mii_mode) begin
            // First nibble only; the byte decision happens next cycle.
            state_d   = ST_PREAMBLE;
            pre_cnt_d = 3'd0;
          end else if (byte_w == PREAMBLE_BYTE) begin
            state_d   = ST_PREAMBLE;
            pre_cnt_d = 3'd1;
          end else if (byte_w == SFD_BYTE) begin
            enter_pl = 1'b1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!rx_dv) begin
          state_d = ST_IDLE;
        end else if (byte_v) begin
          if (byte_w == PREAMBLE_BYTE) begin
            if (pre_cnt_q == 3'd7) state_d = ST_DROP;
            else                   pre_cnt_d = pre_cnt_q + 3'd1;
          end else if (byte_w == SFD_BYTE) begin
            enter_pl = 1'b1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!rx_dv) begin
          // End of frame: at most one of held/partial word exists here.
          if (hold_v_q) begin
            m_data_d  = hold_q;
            m_keep_d  = '1;
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            m_user_d  = bad;
          end else if (lane_q != '0) begin
            m_data_d  = acc_q;
            m_keep_d  = part_keep;
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            m_user_d  = bad;
          end
          done_d   = 1'b1;
          flen_d   = len_q;
          ferr_d   = bad;
          hold_v_d = 1'b0;
          lane_d   = '0;
          state_d  = ST_IDLE;
        end else begin
          if (rx_er) err_d = 1'b1;
          if (byte_v) begin
            if (hold_v_q) begin
              m_data_d  = hold_q;
              m_keep_d  = '1;
              m_valid_d = 1'b1;
              hold_v_d  = 1'b0;
            end
            if (lane_q == LW'(OUT_BYTES - 1)) begin
              hold_d   = acc_ins;
              hold_v_d = 1'b1;
              acc_d    = '0;
              lane_d   = '0;
            end else begin
              acc_d  = acc_ins;
              lane_d = lane_q + LW'(1);
            end
            if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
`ifdef RGMII_RX_FCS_CHECK_EN
            crc_d = crc_nxt;
`endif
          end
        end
      end
      ST_DROP: begin
        if (!rx_dv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_pl) begin
      state_d  = ST_PAYLOAD;
      lane_d   = '0;
      acc_d    = '0;
      hold_v_d = 1'b0;
      len_d    = '0;
      err_d    = 1'b0;
`ifdef RGMII_RX_FCS_CHECK_EN
      crc_d    = 32'hFFFFFFFF;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk_125) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      dv_q      <= 1'b1;
      nib_q     <= 1'b0;
      lo_q      <= '0;
      pre_cnt_q <= '0;
      lane_q    <= '0;
      acc_q     <= '0;
      hold_q    <= '0;
      hold_v_q  <= 1'b0;
      len_q     <= '0;
      err_q     <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_user_q  <= 1'b0;
      done_q    <= 1'b0;
      flen_q    <= '0;
      ferr_q    <= 1'b0;
`ifdef RGMII_RX_FCS_CHECK_EN
      crc_q     <= 32'hFFFFFFFF;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      dv_q      <= rx_dv;
      nib_q     <= nib_d;
      lo_q      <= lo_d;
      pre_cnt_q <= pre_cnt_d;
      lane_q    <= lane_d;
      acc_q     <= acc_d;
      hold_q    <= hold_d;
      hold_v_q  <= hold_v_d;
      len_q     <= len_d;
      err_q     <= err_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
      done_q    <= done_d;
      flen_q    <= flen_d;
      ferr_q    <= ferr_d;
`ifdef RGMII_RX_FCS_CHECK_EN
      crc_q     <= crc_d;
`endif
    end
  end

  assign m_data     = m_data_q;
  assign m_keep     = m_keep_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign m_user     = m_user_q;
  assign frame_done = done_q;
  assign frame_len  = flen_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Scoreboard bench for rgmii_rx_framer with OUT_BYTES=4.
module tb_rgmii_rx_framer;

  localparam int OB = 4;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;
  typedef struct {
    logic [15:0] len;
    logic        err;
  } fres_t;

  logic          clk_125 = 1'b0;
  logic          rst, mii_mode, rx_dv, rx_er;
  logic [7:0]    rx_data;
  logic [8*OB-1:0] m_data;
  logic [OB-1:0] m_keep;
  logic          m_valid, m_last, m_user, frame_done, frame_err;
  logic [15:0]   frame_len;

  beat_t exp_b[$];
  fres_t exp_f[$];
  int    n_chk = 0, n_fail = 0;
  int    beats_seen = 0, done_seen = 0, bidx = 0;
  logic [31:0] first_data, last_data;
  logic [3:0]  last_keep;

  rgmii_rx_framer #(.OUT_BYTES(OB), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk_125(clk_125), .rst(rst), .mii_mode(mii_mode), .rx_data(rx_data),
    .rx_dv(rx_dv), .rx_er(rx_er), .m_data(m_data), .m_keep(m_keep),
    .m_valid(m_valid), .m_last(m_last), .m_user(m_user),
    .frame_done(frame_done), .frame_len(frame_len), .frame_err(frame_err)
  );

  always #4 clk_125 = ~clk_125;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a beat or a frame result.
  always @(negedge clk_125) begin
    if (rst) begin
      bidx = 0;
    end else begin
      if (m_valid) begin
        beats_seen++;
        if (bidx == 0) first_data = m_data;
        bidx++;
        if (m_last) begin
          last_data = m_data;
          last_keep = m_keep;
          bidx = 0;
        end
        if (exp_b.size() == 0) check("beat_unexpected", m_valid, 0);
        else begin
          beat_t e;
          e = exp_b.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_keep", m_keep, e.keep);
          check("beat_last", m_last, e.last);
          if (e.last) check("beat_user", m_user, e.user);
        end
      end
      if (frame_done) begin
        done_seen++;
        if (exp_f.size() == 0) check("done_unexpected", frame_done, 0);
        else begin
          fres_t f;
          f = exp_f.pop_front();
          check("frame_len", frame_len, f.len);
          check("frame_err", frame_err, f.err);
        end
      end
    end
  end

  task automatic cyc(input logic [7:0] d, input logic dv, input logic er);
    rx_data = d; rx_dv = dv; rx_er = er;
    @(posedge clk_125); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(8'h00, 1'b0, 1'b0);
  endtask

  task automatic mk_seq(output bq_t q, input int n, input int start);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'(start + i));
  endtask

  task automatic mk_wire(output bq_t w, input bq_t pl, input int npre);
    w = {};
    for (int i = 0; i < npre; i++) w.push_back(8'h55);
    w.push_back(8'hD5);
    foreach (pl[i]) w.push_back(pl[i]);
  endtask

  task automatic expect_frame(input bq_t pl, input logic err);
    beat_t b;
    fres_t f;
    int n;
    n = pl.size();
    for (int i = 0; i < n; i += OB) begin
      b.data = '0; b.keep = '0;
      for (int j = 0; j < OB; j++)
        if (i + j < n) begin b.data[8*j +: 8] = pl[i+j]; b.keep[j] = 1'b1; end
      b.last = (i + OB >= n);
      b.user = b.last ? err : 1'b0;
      exp_b.push_back(b);
    end
    f.len = 16'(n); f.err = err;
    exp_f.push_back(f);
  endtask

  task automatic send(input bq_t w, input bit nib, input bit xnib, input int er_at);
    for (int i = 0; i < w.size(); i++) begin
      if (nib) begin
        cyc({4'h0, w[i][3:0]}, 1'b1, 1'b0);
        cyc({4'h0, w[i][7:4]}, 1'b1, 1'b0);
      end else begin
        cyc(w[i], 1'b1, i == er_at);
      end
    end
    if (xnib) cyc(8'h0A, 1'b1, 1'b0);
    idle(6);
  endtask

  initial begin
    bq_t pl, w;
    int b0, d0;
    beat_t b;

    rst = 1'b1; mii_mode = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk_125);
    #1;
    check("reset_valid_last_user", {m_valid, m_last, m_user}, 0);
    check("reset_done_err", {frame_done, frame_err}, 0);
    check("reset_data_keep", {m_data, m_keep}, 0);
    check("reset_len", frame_len, 0);
    rst = 1'b0;
    idle(3);

    // 66-byte frame, byte mode
    mk_seq(pl, 66, 0); mk_wire(w, pl, 7);
    b0 = beats_seen; d0 = done_seen;
    expect_frame(pl, 1'b0);
    send(w, 0, 0, -1);
    check("t1_beats", beats_seen - b0, 17);
    check("t1_done", done_seen - d0, 1);
    check("t1_first_data", first_data, 32'h03020100);
    check("t1_last_keep", last_keep, 4'b0011);
    check("t1_last_data_lo", last_data[15:0], 16'h4140);

    // same frame as nibbles, then with a trailing odd nibble
    mii_mode = 1'b1;
    b0 = beats_seen;
    expect_frame(pl, 1'b0);
    send(w, 1, 0, -1);
    check("t2_beats", beats_seen - b0, 17);
    b0 = beats_seen;
    expect_frame(pl, 1'b1);
    send(w, 1, 1, -1);
    check("t2_odd_beats", beats_seen - b0, 17);
    mii_mode = 1'b0;

    // runt
    mk_seq(pl, 30, 8'h10); mk_wire(w, pl, 7);
    b0 = beats_seen;
    expect_frame(pl, 1'b1);
    send(w, 0, 0, -1);
    check("runt_beats", beats_seen - b0, 8);
    check("runt_last_keep", last_keep, 4'b0011);

    // zero-length: SFD only, one cycle of dv
    pl = {};
    b0 = beats_seen; d0 = done_seen;
    expect_frame(pl, 1'b1);
    cyc(8'hD5, 1'b1, 1'b0);
    idle(6);
    check("zero_beats", beats_seen - b0, 0);
    check("zero_done", done_seen - d0, 1);

    // MIN_LEN boundary: 63 bad, 64 good
    mk_seq(pl, 63, 8'h80); mk_wire(w, pl, 7);
    expect_frame(pl, 1'b1);
    send(w, 0, 0, -1);
    mk_seq(pl, 64, 8'h80); mk_wire(w, pl, 7);
    expect_frame(pl, 1'b0);
    send(w, 0, 0, -1);
    check("min_last_keep", last_keep, 4'b1111);

    // bad preamble byte, then too many preamble bytes: both dropped
    b0 = beats_seen; d0 = done_seen;
    mk_seq(pl, 64, 0);
    w = {8'h55, 8'h55, 8'hAA};
    foreach (pl[i]) w.push_back(pl[i]);
    send(w, 0, 0, -1);
    mk_wire(w, pl, 8);
    send(w, 0, 0, -1);
    check("drop_beats", beats_seen - b0, 0);
    check("drop_done", done_seen - d0, 0);
    mk_wire(w, pl, 7);
    expect_frame(pl, 1'b0);
    send(w, 0, 0, -1);
    check("after_drop_done", done_seen - d0, 1);

    // rx_er at payload byte 20
    mk_seq(pl, 64, 8'h40); mk_wire(w, pl, 7);
    expect_frame(pl, 1'b1);
    send(w, 0, 0, 8 + 20);

    // MAX_LEN boundary: 1518 good, 1519 bad (forwarded in full)
    mk_seq(pl, 1518, 0); mk_wire(w, pl, 7);
    expect_frame(pl, 1'b0);
    send(w, 0, 0, -1);
    mk_seq(pl, 1519, 0); mk_wire(w, pl, 7);
    b0 = beats_seen;
    expect_frame(pl, 1'b1);
    send(w, 0, 0, -1);
    check("max_beats", beats_seen - b0, 380);

    // reset at payload byte 10: two full beats escape, nothing else
    b0 = beats_seen; d0 = done_seen;
    b.keep = 4'hF; b.last = 1'b0; b.user = 1'b0;
    b.data = 32'h03020100; exp_b.push_back(b);
    b.data = 32'h07060504; exp_b.push_back(b);
    for (int i = 0; i < 7; i++) cyc(8'h55, 1'b1, 1'b0);
    cyc(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(8'(i), 1'b1, 1'b0);
    rx_data = 8'd10; rx_dv = 1'b1; rst = 1'b1;
    @(posedge clk_125); #1;
    rst = 1'b0;
    check("rst_mid_outs", {m_valid, m_last, m_user, frame_done, frame_err}, 0);
    check("rst_mid_data", {m_data, m_keep, frame_len}, 0);
    cyc(8'h55, 1'b1, 1'b0);
    cyc(8'hD5, 1'b1, 1'b0);
    for (int i = 13; i < 20; i++) cyc(8'(i), 1'b1, 1'b0);
    idle(6);
    check("rst_mid_beats", beats_seen - b0, 2);
    check("rst_mid_done", done_seen - d0, 0);
    mk_seq(pl, 66, 8'h20); mk_wire(w, pl, 7);
    expect_frame(pl, 1'b0);
    send(w, 0, 0, -1);
    check("rst_after_done", done_seen - d0, 1);

    check("beat_queue_drained", exp_b.size(), 0);
    check("frame_queue_drained", exp_f.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
